jtkunio_dwnld: RTL and testbench

JTKUNIO_DWNLD -- requirements
Module: jtkunio_dwnld

---
 rtl/jtkunio_pkg.sv | 37 +++
 rtl/jtkunio_dwnld_fifo.sv | 50 +++++
 rtl/jtkunio_dwnld.sv | 145 ++++++++++++++
 tb/tb_jtkunio_dwnld.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtkunio_pkg.sv
// Shared constants and types for the Kunio ROM download path: region map,
// SDRAM bank encodings, write-queue entry layout and loader FSM states.
package jtkunio_pkg;

  localparam logic [24:0] MAIN_BASE = 25'h00000;
  localparam logic [24:0] SND_BASE  = 25'h10000;
  localparam logic [24:0] PCM_BASE  = 25'h18000;
  localparam logic [24:0] CHAR_BASE = 25'h38000;
  localparam logic [24:0] SCR_BASE  = 25'h48000;
  localparam logic [24:0] OBJ_BASE  = 25'h88000;
  localparam logic [24:0] ROM_LIMIT = 25'h108000;

  typedef enum logic [1:0] {
    BANK_MAIN = 2'd0,
    BANK_PCM  = 2'd1,
    BANK_GFX  = 2'd2,
    BANK_OBJ  = 2'd3
  } bank_e;

  localparam int unsigned FIFO_DEPTH = 4;

  typedef struct packed {
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  mask;
    bank_e       ba;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_e;

endpackage

// File: rtl/jtkunio_dwnld_fifo.sv
// Small synchronous FIFO holding decoded SDRAM writes between the ioctl
// byte stream and the loader FSM. Head entry is visible on dout.
module jtkunio_dwnld_fifo
  import jtkunio_pkg::*;
#(
  parameter int unsigned WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/jtkunio_dwnld.sv
// Kunio ROM downloader: decodes ioctl bytes into SDRAM bank/word writes,
// buffers them in a 4-deep FIFO and issues them one at a time via prog_*.
module jtkunio_dwnld
  import jtkunio_pkg::*;
#(
  parameter logic [24:0] MAIN_START = MAIN_BASE,
  parameter logic [24:0] SND_START  = SND_BASE,
  parameter logic [24:0] PCM_START  = PCM_BASE,
  parameter logic [24:0] CHAR_START = CHAR_BASE,
  parameter logic [24:0] SCR_START  = SCR_BASE,
  parameter logic [24:0] OBJ_START  = OBJ_BASE,
  parameter logic [24:0] ROM_END    = ROM_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [15:0] prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_ba,
  output logic        prog_we,
  output logic        prog_rd,
  input  logic        prog_rdy,
  output logic        dwnld_busy,
  output logic        overflow
);

  state_e               state;
  state_e               state_nx;
  bank_e                bank;
  logic [24:0]          base;
  logic [24:0]          offset;
  logic                 offset_unused;
  logic                 in_rom;
  logic                 wr_ok;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  entry_t               wr_entry;
  entry_t               head;
  logic [ENTRY_W-1:0]   wr_bits;
  logic [ENTRY_W-1:0]   head_bits;

  // Main/snd share bank0 from MAIN_START and char/scr share bank2 from
  // CHAR_START, so each pair decodes to one contiguous word range.
  always_comb begin
    bank = BANK_MAIN;
    base = MAIN_START;
    if (ioctl_addr >= OBJ_START) begin
      bank = BANK_OBJ;
      base = OBJ_START;
    end else if (ioctl_addr >= SCR_START) begin
      bank = BANK_GFX;
      base = CHAR_START;
    end else if (ioctl_addr >= CHAR_START) begin
      bank = BANK_GFX;
      base = CHAR_START;
    end else if (ioctl_addr >= PCM_START) begin
      bank = BANK_PCM;
      base = PCM_START;
    end else if (ioctl_addr >= SND_START) begin
      bank = BANK_MAIN;
      base = MAIN_START;
    end
  end

  assign offset        = ioctl_addr - base;
  assign offset_unused = ^{offset[24:23], offset[0]};
  assign in_rom        = (ioctl_addr < ROM_END);

  always_comb begin
    wr_entry      = '0;
    wr_entry.addr = offset[22:1];
    wr_entry.data = {2{ioctl_dout}};
    wr_entry.mask = ioctl_addr[0] ? 2'b01 : 2'b10;
    wr_entry.ba   = bank;
  end

  assign wr_bits = wr_entry;
  assign head    = entry_t'(head_bits);
  assign wr_ok   = ioctl_wr & downloading & in_rom;
  assign push    = wr_ok & (~fifo_full | pop);

  jtkunio_dwnld_fifo #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (wr_bits),
    .dout  (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (!fifo_empty) state_nx = ST_ISSUE;
      ST_ISSUE: state_nx = ST_WAIT;
      ST_WAIT:  if (prog_rdy) state_nx = fifo_empty ? ST_IDLE : ST_ISSUE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // prog_we is high only in WAIT, so back-to-back writes see it drop for the
  // ISSUE cycle while the next entry settles on prog_*.
  always_comb begin
    pop        = ~fifo_empty & ((state == ST_IDLE) | ((state == ST_WAIT) & prog_rdy));
    prog_we    = ~rst & (state == ST_WAIT);
    dwnld_busy = ~rst & (downloading | ~fifo_empty | (state != ST_IDLE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= '0;
      prog_ba   <= '0;
    end else if (pop) begin
      prog_addr <= head.addr;
      prog_data <= head.data;
      prog_mask <= head.mask;
      prog_ba   <= head.ba;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                           overflow <= 1'b0;
    else if (wr_ok & fifo_full & ~pop) overflow <= 1'b1;
  end

  assign prog_rd = 1'b0;

endmodule

// File: tb/tb_jtkunio_dwnld.sv
// Bench for jtkunio_dwnld: transaction-level queue model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_jtkunio_dwnld;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wr = 1'b0;
  logic        prog_rdy = 1'b0;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_ba;
  logic        prog_we;
  logic        prog_rd;
  logic        dwnld_busy;
  logic        overflow;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  jtkunio_dwnld dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_ba     (prog_ba),
    .prog_we     (prog_we),
    .prog_rd     (prog_rd),
    .prog_rdy    (prog_rdy),
    .dwnld_busy  (dwnld_busy),
    .overflow    (overflow)
  );

  typedef struct {
    logic [21:0] a;
    logic [15:0] d;
    logic [1:0]  m;
    logic [1:0]  b;
  } wr_t;

  // Model: pending queue, one write held by the loader, whether it is on the bus.
  wr_t mq[$];
  wr_t m_cur;
  bit  m_held, m_we, m_ovf;

  function automatic wr_t decode(input logic [24:0] a, input logic [7:0] v);
    wr_t e;
    int unsigned base, bank;
    if (a >= 25'h88000)      begin base = 'h88000; bank = 3; end
    else if (a >= 25'h38000) begin base = 'h38000; bank = 2; end
    else if (a >= 25'h18000) begin base = 'h18000; bank = 1; end
    else                     begin base = 0;       bank = 0; end
    e.a = 22'((32'(a) - base) >> 1);
    e.d = {v, v};
    e.m = a[0] ? 2'b01 : 2'b10;
    e.b = 2'(bank);
    return e;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_step();
    bit done, full, pop, valid;
    if (rst) begin
      mq.delete();
      m_held = 0; m_we = 0; m_ovf = 0;
      m_cur = '{default: '0};
      return;
    end
    done  = m_held && m_we && prog_rdy;
    full  = (mq.size() == 4);
    pop   = (mq.size() != 0) && (!m_held || done);
    valid = ioctl_wr && downloading && (ioctl_addr < 25'h108000);
    if (pop) begin
      m_cur = mq.pop_front(); m_held = 1; m_we = 0;
    end else if (done) begin
      m_held = 0; m_we = 0;
    end else if (m_held) begin
      m_we = 1;
    end
    if (valid) begin
      if (!full || pop) mq.push_back(decode(ioctl_addr, ioctl_dout));
      else m_ovf = 1;
    end
  endfunction

  function automatic void compare();
    n_vec++;
    chk("prog_we",    prog_we,    !rst && m_we);
    chk("dwnld_busy", dwnld_busy, !rst && (downloading || mq.size() != 0 || m_held));
    chk("overflow",   overflow,   m_ovf);
    chk("prog_rd",    prog_rd,    0);
    chk("prog_addr",  prog_addr,  m_cur.a);
    chk("prog_data",  prog_data,  m_cur.d);
    chk("prog_mask",  prog_mask,  m_cur.m);
    chk("prog_ba",    prog_ba,    m_cur.b);
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] v);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = v;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_we();
    for (int i = 0; i < 20; i++) begin
      if (prog_we) return;
      tick();
    end
    chk("prog_we_timeout", prog_we, 1);
  endtask

  task automatic drain_one(output logic [15:0] d, output logic [21:0] a);
    wait_we();
    d = prog_data; a = prog_addr;
    prog_rdy = 1'b1;
    tick();
    prog_rdy = 1'b0;
  endtask

  task automatic burst6();
    for (int i = 0; i < 6; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(32'h100 + i); ioctl_dout = 8'(8'h11 * (i + 1));
      tick();
    end
    ioctl_wr = 1'b0;
  endtask

  logic [24:0] bnd [7] = '{25'h0, 25'h10000, 25'h18000, 25'h38000, 25'h48000, 25'h88000, 25'h108000};

  initial begin
    logic [15:0] d;
    logic [21:0] a;

    downloading = 1'b1; rst = 1'b1;
    tick(); tick();
    chk("rst_we", prog_we, 0);
    chk("rst_busy", dwnld_busy, 0);
    chk("rst_addr", prog_addr, 0);
    chk("rst_data", prog_data, 0);
    chk("rst_mask", prog_mask, 0);
    chk("rst_ba", prog_ba, 0);
    rst = 1'b0;

    wr_byte(25'h00003, 8'hA5);
    chk("a5_latency", prog_we, 0);
    tick();
    chk("a5_issue", prog_we, 0);
    wait_we();
    chk("a5_ba", prog_ba, 0);
    chk("a5_addr", prog_addr, 1);
    chk("a5_mask", prog_mask, 2'b01);
    chk("a5_data", prog_data, 16'hA5A5);
    repeat (3) tick();
    chk("a5_hold", prog_we, 1);
    prog_rdy = 1'b1; tick(); prog_rdy = 1'b0;
    chk("a5_done", prog_we, 0);

    wr_byte(25'h38004, 8'h5A);
    wait_we();
    chk("char_ba", prog_ba, 2);
    chk("char_addr", prog_addr, 2);
    chk("char_mask", prog_mask, 2'b10);
    prog_rdy = 1'b1; tick(); prog_rdy = 1'b0;
    wr_byte(25'h88001, 8'h3C);
    wait_we();
    chk("obj_ba", prog_ba, 3);
    chk("obj_addr", prog_addr, 0);
    chk("obj_mask", prog_mask, 2'b01);
    prog_rdy = 1'b1; tick(); prog_rdy = 1'b0;

    wr_byte(25'h108000, 8'h77);
    repeat (4) tick();
    chk("oor_we", prog_we, 0);
    downloading = 1'b0;
    tick();
    chk("oor_busy", dwnld_busy, 0);
    wr_byte(25'h00010, 8'h99);
    repeat (3) tick();
    chk("nodl_we", prog_we, 0);
    chk("nodl_busy", dwnld_busy, 0);

    downloading = 1'b1;
    burst6();
    chk("burst_ovf", overflow, 1);
    for (int i = 0; i < 5; i++) begin
      drain_one(d, a);
      chk("burst_data", d, {2{8'(8'h11 * (i + 1))}});
      chk("burst_addr", a, 22'(32'h80 + i / 2));
    end
    repeat (3) tick();
    chk("burst_empty_we", prog_we, 0);

    rst = 1'b1; tick(); rst = 1'b0;
    chk("ovf_cleared", overflow, 0);

    for (int i = 0; i < 3; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(32'h20000 + i); ioctl_dout = 8'(i + 1);
      tick();
    end
    ioctl_wr = 1'b0; downloading = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_we();
      chk("tail_busy_hi", dwnld_busy, 1);
      prog_rdy = 1'b1; tick(); prog_rdy = 1'b0;
    end
    chk("tail_busy_lo", dwnld_busy, 0);

    downloading = 1'b1;
    burst6();
    wait_we();
    downloading = 1'b0; rst = 1'b1;
    tick();
    chk("rstw_we", prog_we, 0);
    chk("rstw_busy", dwnld_busy, 0);
    chk("rstw_ovf", overflow, 0);
    rst = 1'b0;
    repeat (4) tick();
    chk("rstw_noretry", prog_we, 0);

    for (int c = 0; c < 4000; c++) begin
      rst         = ($urandom_range(0, 399) == 0);
      downloading = ($urandom_range(0, 9) != 0);
      ioctl_wr    = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0)
        ioctl_addr = 25'(bnd[$urandom_range(0, 6)] + $urandom_range(0, 3) - 32'd2);
      else
        ioctl_addr = 25'($urandom_range(0, 32'h10FFFF));
      ioctl_dout  = 8'($urandom);
      prog_rdy    = prog_we ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      tick();
    end

    rst = 1'b0; downloading = 1'b0; ioctl_wr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      prog_rdy = prog_we;
      tick();
    end
    prog_rdy = 1'b0;
    chk("final_idle", dwnld_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
